// File: rtl/md_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package md_pkg;

    // Function codes, identical to the controller's MDFunc encoding.
    localparam logic [2:0] MD_NONE = 3'd0;
    localparam logic [2:0] MD_MTHI = 3'd1;
    localparam logic [2:0] MD_MTLO = 3'd2;
    localparam logic [2:0] MD_MUL  = 3'd3;
    localparam logic [2:0] MD_DIV  = 3'd4;

    // One quotient bit per iteration.
    localparam int unsigned DIV_ITERS = 32;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

    // Magnitude of a two's-complement value when en is set, raw value otherwise.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative unsigned restoring divider: load once, then one quotient bit per step.
module md_divider (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] trial;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        // Bit 32 set means the shifted remainder was smaller than the divisor.
        trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (step_i) begin
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = {rem_q[30:0], quo_q[31]};
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning the HI/LO registers.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic        md_cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        md_busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state_q, state_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sign_q, sign_d;

    logic        accept;
    logic        div_load;
    logic        div_step;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] a_ext, b_ext, prod;
    logic        q_neg, r_neg, div_zero;

    assign accept = (state_q == IDLE) && md_start && !md_cancel;

    // Widen the latched operands so one 64-bit multiply serves mult and multu.
    always_comb begin
        a_ext = sign_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext = sign_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = a_ext * b_ext;
    end

    assign q_neg    = sign_q && (a_q[31] ^ b_q[31]);
    assign r_neg    = sign_q && a_q[31];
    assign div_zero = (b_q == 32'd0);

    md_divider u_divider (
        .clk_i       (clk),
        .rst_ni      (reset),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (md_abs(rs_val, md_sign)),
        .divisor_i   (md_abs(rt_val, md_sign)),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    // Next-state logic: acceptance, iteration counting, result write-back.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (md_func)
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        MD_MUL: begin
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sign_d  = md_sign;
                            cnt_d   = 6'(MUL_LAT - 1);
                            busy_d  = 1'b1;
                            state_d = MUL;
                        end
                        MD_DIV: begin
                            a_d      = rs_val;
                            b_d      = rt_val;
                            sign_d   = md_sign;
                            div_load = 1'b1;
                            cnt_d    = 6'(DIV_ITERS - 1);
                            busy_d   = 1'b1;
                            state_d  = DIV;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (md_cancel) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == 6'd0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DIV: begin
                if (md_cancel) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_step = 1'b1;
                    if (cnt_q == 6'd0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!md_cancel) begin
                    // Divide by zero returns the raw dividend and all-ones quotient.
                    if (div_zero) begin
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = r_neg ? (~rem + 32'd1) : rem;
                        lo_d = q_neg ? (~quo + 32'd1) : quo;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and architectural registers; reset takes effect immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
        end
    end

    assign md_busy = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        md_start;
    logic [2:0]  md_func;
    logic        md_sign;
    logic        md_cancel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;
    int n;

    md_unit #(.MUL_LAT(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_func   (md_func),
        .md_sign   (md_sign),
        .md_cancel (md_cancel),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .md_busy   (md_busy),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and count the cycles md_busy stays high afterwards.
    // cancel_at / restart_at name the busy cycle on which to pulse md_cancel or
    // a second md_start (0 = never).
    task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int cancel_at, input int restart_at,
                          output int cycles);
        md_func   = f;
        md_sign   = s;
        rs_val    = a;
        rt_val    = b;
        md_start  = 1'b1;
        md_cancel = 1'b0;
        #1;
        check("busy_before_accept", {31'd0, md_busy}, 32'd0);
        tick;
        md_start = 1'b0;
        md_func  = MD_NONE;
        rs_val   = 32'hDEAD_BEEF;
        rt_val   = 32'h0BAD_F00D;
        cycles   = 0;
        while (md_busy === 1'b1 && cycles < 100) begin
            cycles++;
            md_cancel = (cycles == cancel_at);
            if (cycles == restart_at) begin
                md_start = 1'b1;
                md_func  = MD_DIV;
                md_sign  = 1'b0;
                rs_val   = 32'd5;
                rt_val   = 32'd1;
            end else begin
                md_start = 1'b0;
                md_func  = MD_NONE;
            end
            tick;
        end
        md_start  = 1'b0;
        md_cancel = 1'b0;
        md_func   = MD_NONE;
    endtask

    initial begin
        reset     = 1'b0;
        md_start  = 1'b0;
        md_func   = MD_NONE;
        md_sign   = 1'b0;
        md_cancel = 1'b0;
        rs_val    = '0;
        rt_val    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick;

        // mult -3 * 7
        run_op(MD_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7, 0, 0, n);
        check("mult_busy_cycles", 32'(n), 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        // multu max*max with a second start during busy
        run_op(MD_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2, n);
        check("multu_busy_cycles", 32'(n), 32'd5);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        tick;
        check("multu_no_restart", {31'd0, md_busy}, 32'd0);

        // div -7 / 2
        run_op(MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, n);
        check("div_busy_cycles", 32'(n), 32'd33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // divu 100 / 7
        run_op(MD_DIV, 1'b0, 32'd100, 32'd7, 0, 0, n);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // divu by zero
        run_op(MD_DIV, 1'b0, 32'h0000_1234, 32'd0, 0, 0, n);
        check("divz_busy_cycles", 32'(n), 32'd33);
        check("divz_hi", hi, 32'h0000_1234);
        check("divz_lo", lo, 32'hFFFF_FFFF);

        // signed divide by zero, negative dividend
        run_op(MD_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0, 0, 0, n);
        check("sdivz_hi", hi, 32'hFFFF_FFFB);
        check("sdivz_lo", lo, 32'hFFFF_FFFF);

        // signed overflow
        run_op(MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, n);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);

        // illegal function code is ignored
        md_func  = 3'd7;
        rs_val   = 32'h1234_5678;
        md_start = 1'b1;
        tick;
        md_start = 1'b0;
        check("func7_busy", {31'd0, md_busy}, 32'd0);
        check("func7_hi", hi, 32'h0000_0000);
        check("func7_lo", lo, 32'h8000_0000);

        // start with cancel in IDLE is ignored
        md_func   = MD_MTHI;
        rs_val    = 32'h1111_1111;
        md_start  = 1'b1;
        md_cancel = 1'b1;
        tick;
        md_start  = 1'b0;
        md_cancel = 1'b0;
        check("cancel_idle_hi", hi, 32'h0000_0000);

        // mthi then mtlo on consecutive cycles
        md_func  = MD_MTHI;
        rs_val   = 32'hA5A5_A5A5;
        md_start = 1'b1;
        #1;
        check("mthi_pre_edge_hi", hi, 32'h0000_0000);
        tick;
        check("mthi_hi", hi, 32'hA5A5_A5A5);
        check("mthi_lo_kept", lo, 32'h8000_0000);
        check("mthi_busy", {31'd0, md_busy}, 32'd0);
        md_func = MD_MTLO;
        rs_val  = 32'h5A5A_5A5A;
        #1;
        check("mtlo_pre_edge_lo", lo, 32'h8000_0000);
        tick;
        md_start = 1'b0;
        md_func  = MD_NONE;
        check("mtlo_lo", lo, 32'h5A5A_5A5A);
        check("mtlo_hi_kept", hi, 32'hA5A5_A5A5);
        check("mtlo_busy", {31'd0, md_busy}, 32'd0);

        // div cancelled at busy cycle 10
        run_op(MD_DIV, 1'b1, 32'd50, 32'd7, 10, 0, n);
        check("cancel_busy_cycles", 32'(n), 32'd10);
        check("cancel_hi", hi, 32'hA5A5_A5A5);
        check("cancel_lo", lo, 32'h5A5A_5A5A);
        tick;
        check("cancel_stays_idle", {31'd0, md_busy}, 32'd0);

        // async reset in the middle of a divide
        md_func  = MD_DIV;
        md_sign  = 1'b1;
        rs_val   = 32'd1000;
        rt_val   = 32'd3;
        md_start = 1'b1;
        tick;
        md_start = 1'b0;
        md_func  = MD_NONE;
        repeat (19) tick;
        check("rst_mid_busy_before", {31'd0, md_busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, md_busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick;

        // mult after reset release: -6 * 7
        run_op(MD_MUL, 1'b1, 32'hFFFF_FFFA, 32'd7, 0, 0, n);
        check("post_rst_busy_cycles", 32'(n), 32'd5);
        check("post_rst_hi", hi, 32'hFFFF_FFFF);
        check("post_rst_lo", lo, 32'hFFFF_FFD6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
